// File: rtl/config_int_add_err_mon_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | config_int_add_err_mon_pkg : shared state encoding, widths, helper function |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
package config_int_add_err_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } state_e;

   localparam int c_DEF_DPW = 32;
   localparam int c_DEF_ACC = 48;
   localparam int c_DEF_WIN = 16;

   localparam logic [c_DEF_ACC-1:0] c_ACC_SAT_MAX = '1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/config_int_add_err_mon_abs_diff_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | abs_diff_reg : registered unsigned |x - y| with a registered valid flag      |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module abs_diff_reg #(
   parameter int DATA_PATH_BITWIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_valid,
   input  logic [DATA_PATH_BITWIDTH-1:0] i_x,
   input  logic [DATA_PATH_BITWIDTH-1:0] i_y,
   output logic                          o_valid,
   output logic [DATA_PATH_BITWIDTH-1:0] o_diff
);

   logic                          r_valid;
   logic [DATA_PATH_BITWIDTH-1:0] r_diff;
   logic [DATA_PATH_BITWIDTH-1:0] w_diff;

   assign w_diff = (i_x >= i_y) ? (i_x - i_y) : (i_y - i_x);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_diff  <= '0;
      end else begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_diff <= w_diff;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_diff  = r_diff;

endmodule
`default_nettype wire

// File: rtl/config_int_add_err_mon.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | config_int_add_err_mon : windowed |approx - exact| error monitor that drives |
// | the adder's approximation enable from the per-window error budget           |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module config_int_add_err_mon
   import config_int_add_err_mon_pkg::*;
#(
   parameter int DATA_PATH_BITWIDTH = c_DEF_DPW,
   parameter int ACC_BITWIDTH       = c_DEF_ACC,
   parameter int WIN_BITWIDTH       = c_DEF_WIN
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start,
   input  logic                          i_continuous,
   input  logic [WIN_BITWIDTH-1:0]       i_win_len,
   input  logic [ACC_BITWIDTH-1:0]       i_err_budget,
   input  logic                          i_in_valid,
   input  logic [DATA_PATH_BITWIDTH-1:0] i_apx_c,
   input  logic [DATA_PATH_BITWIDTH-1:0] i_exact_c,
   output logic                          o_apx_ctl,
   output logic                          o_busy,
   output logic                          o_win_done,
   output logic [ACC_BITWIDTH-1:0]       o_err_sum,
   output logic                          o_over_budget
);

   // Sum width wide enough that acc + d never wraps before the saturation test
   localparam int c_SW = max_int(DATA_PATH_BITWIDTH, ACC_BITWIDTH) + 1;
   localparam logic [ACC_BITWIDTH-1:0] c_ACC_MAX = '1;

   state_e                          r_state;
   state_e                          w_state_nxt;
   logic [WIN_BITWIDTH-1:0]         r_win_len;
   logic [WIN_BITWIDTH-1:0]         r_cnt;
   logic [ACC_BITWIDTH-1:0]         r_budget;
   logic [ACC_BITWIDTH-1:0]         r_acc;
   logic [ACC_BITWIDTH-1:0]         r_err_sum;
   logic                            r_over;
   logic                            r_apx_ctl;
   logic                            r_acc_vld;

   logic                            w_sample;
   logic                            w_start_acc;
   logic [WIN_BITWIDTH-1:0]         w_cnt_nxt;
   logic [WIN_BITWIDTH-1:0]         w_win_len_eff;
   logic                            w_over;
   logic                            w_s1_vld;
   logic [DATA_PATH_BITWIDTH-1:0]   w_s1_diff;
   logic [c_SW-1:0]                 w_sum;
   logic [ACC_BITWIDTH-1:0]         w_acc_nxt;

   assign w_sample      = (r_state == ST_RUN) && i_in_valid;
   assign w_start_acc   = (r_state == ST_IDLE) && i_start;
   assign w_cnt_nxt     = w_sample ? (r_cnt + WIN_BITWIDTH'(1)) : r_cnt;
   assign w_win_len_eff = (i_win_len == '0) ? WIN_BITWIDTH'(1) : i_win_len;
   assign w_over        = (r_acc > r_budget);

   abs_diff_reg #(
      .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH)
   ) u_abs_diff (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_sample),
      .i_x     (i_apx_c),
      .i_y     (i_exact_c),
      .o_valid (w_s1_vld),
      .o_diff  (w_s1_diff)
   );

   assign w_sum     = c_SW'(r_acc) + c_SW'(w_s1_diff);
   assign w_acc_nxt = (w_sum > c_SW'(c_ACC_MAX)) ? c_ACC_MAX : w_sum[ACC_BITWIDTH-1:0];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (i_start) w_state_nxt = ST_RUN;
         // The sample that reaches the window length is counted in this same cycle
         ST_RUN:    if (w_sample && (w_cnt_nxt == r_win_len)) w_state_nxt = ST_DRAIN;
         ST_DRAIN:  if (!w_s1_vld && !r_acc_vld) w_state_nxt = ST_REPORT;
         ST_REPORT: w_state_nxt = i_continuous ? ST_RUN : ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_win_len <= '0;
         r_cnt     <= '0;
         r_budget  <= '0;
         r_acc     <= '0;
         r_err_sum <= '0;
         r_over    <= 1'b0;
         r_apx_ctl <= 1'b0;
         r_acc_vld <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc_vld <= w_s1_vld;
         if (w_start_acc) begin
            r_win_len <= w_win_len_eff;
            r_budget  <= i_err_budget;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_apx_ctl <= 1'b1;
         end else if (r_state == ST_REPORT) begin
            r_err_sum <= r_acc;
            r_over    <= w_over;
            r_apx_ctl <= ~w_over;
            r_acc     <= '0;
            r_cnt     <= '0;
         end else begin
            r_cnt <= w_cnt_nxt;
            if (w_s1_vld) begin
               r_acc <= w_acc_nxt;
            end
         end
      end
   end

   assign o_apx_ctl     = r_apx_ctl;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_win_done    = (r_state == ST_REPORT);
   assign o_err_sum     = r_err_sum;
   assign o_over_budget = r_over;

endmodule
`default_nettype wire

// File: tb/tb_config_int_add_err_mon.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_config_int_add_err_mon : scoreboard bench for the window error monitor   |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_config_int_add_err_mon;

   typedef struct packed {
      logic [47:0] sum;
      logic        over;
      logic        apx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_continuous = 1'b0;
   logic [15:0] i_win_len = '0;
   logic [31:0] i_apx_c = '0;
   logic [31:0] i_exact_c = '0;
   logic        i_start_a = 1'b0;
   logic        i_in_valid_a = 1'b0;
   logic [47:0] i_err_budget_a = '0;
   logic        i_start_b = 1'b0;
   logic        i_in_valid_b = 1'b0;
   logic [7:0]  i_err_budget_b = '0;

   logic        o_apx_ctl_a, o_busy_a, o_win_done_a, o_over_a;
   logic [47:0] o_err_sum_a;
   logic        o_apx_ctl_b, o_busy_b, o_win_done_b, o_over_b;
   logic [7:0]  o_err_sum_b;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic sel_b = 1'b0;

   always #5 clk = ~clk;

   config_int_add_err_mon u_dut_a (
      .clk (clk), .rst (rst), .i_start (i_start_a), .i_continuous (i_continuous),
      .i_win_len (i_win_len), .i_err_budget (i_err_budget_a), .i_in_valid (i_in_valid_a),
      .i_apx_c (i_apx_c), .i_exact_c (i_exact_c), .o_apx_ctl (o_apx_ctl_a),
      .o_busy (o_busy_a), .o_win_done (o_win_done_a), .o_err_sum (o_err_sum_a),
      .o_over_budget (o_over_a)
   );

   config_int_add_err_mon #(
      .DATA_PATH_BITWIDTH (32), .ACC_BITWIDTH (8), .WIN_BITWIDTH (16)
   ) u_dut_b (
      .clk (clk), .rst (rst), .i_start (i_start_b), .i_continuous (i_continuous),
      .i_win_len (i_win_len), .i_err_budget (i_err_budget_b), .i_in_valid (i_in_valid_b),
      .i_apx_c (i_apx_c), .i_exact_c (i_exact_c), .o_apx_ctl (o_apx_ctl_b),
      .o_busy (o_busy_b), .o_win_done (o_win_done_b), .o_err_sum (o_err_sum_b),
      .o_over_budget (o_over_b)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Results are registered at the end of REPORT, so compare one edge after win_done
   always begin
      @(negedge clk);
      if (o_win_done_a) begin
         @(posedge clk);
         #1;
         if (qa.size() == 0) begin
            chk("a_unexpected_win_done", 64'(o_err_sum_a), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_err_sum", 64'(o_err_sum_a), 64'(e.sum));
            chk("a_over_budget", 64'(o_over_a), 64'(e.over));
            chk("a_apx_ctl", 64'(o_apx_ctl_a), 64'(e.apx));
         end
      end
   end

   always begin
      @(negedge clk);
      if (o_win_done_b) begin
         @(posedge clk);
         #1;
         if (qb.size() == 0) begin
            chk("b_unexpected_win_done", 64'(o_err_sum_b), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_err_sum", 64'(o_err_sum_b), 64'(e.sum));
            chk("b_over_budget", 64'(o_over_b), 64'(e.over));
            chk("b_apx_ctl", 64'(o_apx_ctl_b), 64'(e.apx));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] len, input logic [47:0] budget, input logic cont);
      i_win_len      = len;
      i_err_budget_a = budget;
      i_err_budget_b = budget[7:0];
      i_continuous   = cont;
      if (sel_b) i_start_b = 1'b1; else i_start_a = 1'b1;
      tick();
      i_start_a = 1'b0;
      i_start_b = 1'b0;
   endtask

   task automatic send(input logic [31:0] apx, input logic [31:0] exact);
      i_apx_c   = apx;
      i_exact_c = exact;
      if (sel_b) i_in_valid_b = 1'b1; else i_in_valid_a = 1'b1;
      tick();
      i_in_valid_a = 1'b0;
      i_in_valid_b = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 100; i++) begin
         if (!(sel_b ? o_busy_b : o_busy_a)) break;
         tick();
      end
      chk(nm, 64'(sel_b ? o_busy_b : o_busy_a), 64'd0);
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (o_win_done_a) break;
      end
      chk(nm, 64'(o_win_done_a), 64'd1);
   endtask

   initial begin
      // 1: reset state
      tick(); tick();
      chk("rst_apx_ctl", 64'(o_apx_ctl_a), 64'd0);
      chk("rst_busy", 64'(o_busy_a), 64'd0);
      chk("rst_err_sum", 64'(o_err_sum_a), 64'd0);
      chk("rst_win_done", 64'(o_win_done_a), 64'd0);
      chk("rst_over", 64'(o_over_a), 64'd0);
      rst = 1'b0;
      tick();

      // 2: apx below exact by 2, four samples, within budget
      do_start(16'd4, 48'd10, 1'b0);
      chk("busy_after_start", 64'(o_busy_a), 64'd1);
      chk("apx_ctl_after_start", 64'(o_apx_ctl_a), 64'd1);
      qa.push_back('{sum: 48'd8, over: 1'b0, apx: 1'b1});
      for (int i = 0; i < 4; i++) send(32'd1000 + 32'(i) - 32'd2, 32'd1000 + 32'(i));
      wait_idle("t2_idle");
      chk("t2_apx_held_idle", 64'(o_apx_ctl_a), 64'd1);

      // 3: apx above exact by 3, over budget; extra in_valid in IDLE must be dropped
      send(32'd9, 32'd0);
      do_start(16'd4, 48'd10, 1'b0);
      qa.push_back('{sum: 48'd12, over: 1'b1, apx: 1'b0});
      for (int i = 0; i < 4; i++) send(32'd503, 32'd500);
      wait_idle("t3_idle");

      // 4: win_len of 0 behaves as 1; error equal to budget is within budget
      do_start(16'd0, 48'd5, 1'b0);
      qa.push_back('{sum: 48'd5, over: 1'b0, apx: 1'b1});
      send(32'd20, 32'd25);
      wait_idle("t4_idle");

      // 5: continuous windows with gapped samples
      do_start(16'd2, 48'd3, 1'b1);
      qa.push_back('{sum: 48'd2, over: 1'b0, apx: 1'b1});
      send(32'd11, 32'd10);
      tick();
      send(32'd10, 32'd11);
      wait_done("t5_first_done");
      tick();
      qa.push_back('{sum: 48'd14, over: 1'b1, apx: 1'b0});
      send(32'd7, 32'd0);
      tick(); tick();
      send(32'd0, 32'd7);
      i_continuous = 1'b0;
      wait_idle("t5_idle");

      // 6: reset mid-window discards the partial window
      do_start(16'd4, 48'd100, 1'b0);
      send(32'd9, 32'd0);
      send(32'd9, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_busy_after_rst", 64'(o_busy_a), 64'd0);
      chk("t6_err_sum_after_rst", 64'(o_err_sum_a), 64'd0);
      chk("t6_apx_after_rst", 64'(o_apx_ctl_a), 64'd0);
      tick(); tick(); tick();
      do_start(16'd1, 48'd10, 1'b0);
      qa.push_back('{sum: 48'd3, over: 1'b0, apx: 1'b1});
      send(32'd3, 32'd6);
      wait_idle("t6_idle");

      // 7: 8-bit accumulator saturates
      sel_b = 1'b1;
      do_start(16'd3, 48'd10, 1'b0);
      qb.push_back('{sum: 48'd255, over: 1'b1, apx: 1'b0});
      for (int i = 0; i < 3; i++) send(32'd0, 32'd200);
      wait_idle("t7_idle");
      sel_b = 1'b0;

      tick(); tick(); tick();
      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
